// File: rtl/vo_pkg.sv
// rtl/vo_pkg.sv - shared types for the visual-odometry keypoint pipeline
package vo_pkg;
    localparam int COOR_W  = 10;
    localparam int TRIG_W  = 12;
    localparam int SCORE_W = 8;
    localparam int DEPTH_W = 10;

    typedef struct packed {
        logic [TRIG_W-1:0]  sin;
        logic [TRIG_W-1:0]  cos;
        logic [COOR_W-1:0]  x;
        logic [COOR_W-1:0]  y;
        logic [SCORE_W-1:0] score;
        logic [DEPTH_W-1:0] depth;
    } keypoint_t;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} sched_state_e;
endpackage

// File: rtl/raster_counter.sv
// rtl/raster_counter.sv - raster x/y position of the pixel presented this cycle
module raster_counter
    import vo_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int CW    = COOR_W + 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_load_zero,
    input  logic          i_en,
    output logic [CW-1:0] o_x,
    output logic [CW-1:0] o_y,
    output logic          o_last
);
    logic [CW-1:0] base_x;
    logic [CW-1:0] base_y;

    // A load makes (0,0) the current pixel so it can be consumed on the same cycle.
    always_comb begin
        base_x = i_load_zero ? '0 : o_x;
        base_y = i_load_zero ? '0 : o_y;
    end

    assign o_last = (base_x == CW'(IMG_W - 1)) && (base_y == CW'(IMG_H - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_x <= '0;
            o_y <= '0;
        end else if (i_en) begin
            if (base_x == CW'(IMG_W - 1)) begin
                o_x <= '0;
                o_y <= (base_y == CW'(IMG_H - 1)) ? '0 : base_y + 1'b1;
            end else begin
                o_x <= base_x + 1'b1;
                o_y <= base_y;
            end
        end else if (i_load_zero) begin
            o_x <= '0;
            o_y <= '0;
        end
    end
endmodule

// File: rtl/key_buffer_sched.sv
// rtl/key_buffer_sched.sv - admits keypoints into the BRIEF buffer and pops the head once its window is complete
module key_buffer_sched
    import vo_pkg::*;
#(
    parameter int SIZE     = 60,
    parameter int IMG_W    = 640,
    parameter int IMG_H    = 480,
    parameter int LAG_COLS = 15,
    parameter int LAG_ROWS = 15
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_frame_start,
    input  logic               i_pix_valid,
    input  logic               i_key_valid,
    input  logic [COOR_W-1:0]  i_key_x,
    input  logic [COOR_W-1:0]  i_key_y,
    input  logic [TRIG_W-1:0]  i_key_sin,
    input  logic [TRIG_W-1:0]  i_key_cos,
    input  logic [SCORE_W-1:0] i_key_score,
    input  logic [DEPTH_W-1:0] i_key_depth,
    input  logic [COOR_W-1:0]  i_head_x,
    input  logic [COOR_W-1:0]  i_head_y,
    output logic               o_flag,
    output logic               o_hit,
    output logic [COOR_W-1:0]  o_key_x,
    output logic [COOR_W-1:0]  o_key_y,
    output logic [TRIG_W-1:0]  o_key_sin,
    output logic [TRIG_W-1:0]  o_key_cos,
    output logic [SCORE_W-1:0] o_key_score,
    output logic [DEPTH_W-1:0] o_key_depth,
    output logic               o_ready,
    output logic [6:0]         o_occupancy,
    output logic               o_full,
    output logic               o_empty,
    output logic [15:0]        o_drop_cnt
);
    localparam int CW = COOR_W + 1;

    sched_state_e  state;
    keypoint_t     key_q;
    logic [CW-1:0] cur_x;
    logic [CW-1:0] cur_y;
    logic          last_pix;
    logic          start;
    logic          pix_en;
    logic          head_match;
    logic          hit_c;
    logic          flag_c;
    logic          rejected;
    logic [6:0]    occ_next;

    assign start  = (state == IDLE) && i_frame_start;
    assign pix_en = i_pix_valid && ((state == RUN) || start);

    raster_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .CW    (CW)
    ) u_raster (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_load_zero (start),
        .i_en        (pix_en),
        .o_x         (cur_x),
        .o_y         (cur_y),
        .o_last      (last_pix)
    );

    assign o_full  = (o_occupancy == 7'(SIZE));
    assign o_empty = (o_occupancy == 7'd0);
    assign o_ready = (state == RUN);

    // Widened compare: targets past the frame edge never match and are left for FLUSH.
    assign head_match = (({1'b0, i_head_x} + CW'(LAG_COLS)) == cur_x) &&
                        (({1'b0, i_head_y} + CW'(LAG_ROWS)) == cur_y);

    // o_hit doubles as the block: the buffer head is stale for the cycle after a pop.
    always_comb begin
        hit_c = 1'b0;
        case (state)
            RUN:     hit_c = !o_empty && !o_hit && head_match;
            FLUSH:   hit_c = !o_empty && !o_hit;
            default: hit_c = 1'b0;
        endcase
    end

    assign flag_c   = i_key_valid && (state == RUN) && (!o_full || hit_c);
    assign rejected = i_key_valid && !flag_c;

    always_comb begin
        occ_next = o_occupancy;
        if (flag_c && !hit_c)
            occ_next = o_occupancy + 7'd1;
        else if (hit_c && !flag_c)
            occ_next = o_occupancy - 7'd1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            o_flag      <= 1'b0;
            o_hit       <= 1'b0;
            key_q       <= '0;
            o_occupancy <= '0;
            o_drop_cnt  <= '0;
        end else begin
            o_flag      <= flag_c;
            o_hit       <= hit_c;
            key_q       <= '{sin: i_key_sin, cos: i_key_cos, x: i_key_x, y: i_key_y,
                             score: i_key_score, depth: i_key_depth};
            o_occupancy <= occ_next;

            if (i_frame_start)
                o_drop_cnt <= rejected ? 16'd1 : 16'd0;
            else if (rejected && (o_drop_cnt != 16'hFFFF))
                o_drop_cnt <= o_drop_cnt + 16'd1;

            case (state)
                IDLE:    if (i_frame_start) state <= RUN;
                RUN:     if (pix_en && last_pix) state <= (occ_next != 7'd0) ? FLUSH : IDLE;
                FLUSH:   if (occ_next == 7'd0) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign o_key_x     = key_q.x;
    assign o_key_y     = key_q.y;
    assign o_key_sin   = key_q.sin;
    assign o_key_cos   = key_q.cos;
    assign o_key_score = key_q.score;
    assign o_key_depth = key_q.depth;

    a_no_hit_empty: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        hit_c |-> (o_occupancy != 7'd0));
    a_no_flag_full: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (flag_c && !hit_c) |-> (o_occupancy != 7'(SIZE)));
endmodule

// File: tb/tb_key_buffer_sched.sv
// tb/tb_key_buffer_sched.sv - directed bench for key_buffer_sched with a FIFO stand-in for the keypoint buffer
module tb_key_buffer_sched;
    import vo_pkg::*;

    localparam int W    = 64;
    localparam int H    = 40;
    localparam int SIZE = 60;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               i_frame_start = 1'b0;
    logic               i_pix_valid = 1'b0;
    logic               i_key_valid = 1'b0;
    logic [COOR_W-1:0]  i_key_x = '0;
    logic [COOR_W-1:0]  i_key_y = '0;
    logic [TRIG_W-1:0]  i_key_sin = '0;
    logic [TRIG_W-1:0]  i_key_cos = '0;
    logic [SCORE_W-1:0] i_key_score = '0;
    logic [DEPTH_W-1:0] i_key_depth = '0;
    logic [COOR_W-1:0]  i_head_x = '0;
    logic [COOR_W-1:0]  i_head_y = '0;
    logic               o_flag, o_hit, o_ready, o_full, o_empty;
    logic [COOR_W-1:0]  o_key_x, o_key_y;
    logic [TRIG_W-1:0]  o_key_sin, o_key_cos;
    logic [SCORE_W-1:0] o_key_score;
    logic [DEPTH_W-1:0] o_key_depth;
    logic [6:0]         o_occupancy;
    logic [15:0]        o_drop_cnt;

    int errors = 0;
    int checks = 0;
    int hit_cnt = 0;
    int bx = 0;
    int by = 0;
    int h0;

    typedef struct {int x; int y;} ent_t;
    ent_t buf_q[$];
    logic pf = 1'b0, ph = 1'b0;
    logic [COOR_W-1:0] pkx = '0, pky = '0;

    always #5 clk = ~clk;

    key_buffer_sched #(
        .SIZE(SIZE), .IMG_W(W), .IMG_H(H), .LAG_COLS(15), .LAG_ROWS(15)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_frame_start(i_frame_start), .i_pix_valid(i_pix_valid),
        .i_key_valid(i_key_valid), .i_key_x(i_key_x), .i_key_y(i_key_y),
        .i_key_sin(i_key_sin), .i_key_cos(i_key_cos), .i_key_score(i_key_score),
        .i_key_depth(i_key_depth), .i_head_x(i_head_x), .i_head_y(i_head_y),
        .o_flag(o_flag), .o_hit(o_hit), .o_key_x(o_key_x), .o_key_y(o_key_y),
        .o_key_sin(o_key_sin), .o_key_cos(o_key_cos), .o_key_score(o_key_score),
        .o_key_depth(o_key_depth), .o_ready(o_ready), .o_occupancy(o_occupancy),
        .o_full(o_full), .o_empty(o_empty), .o_drop_cnt(o_drop_cnt)
    );

    // Buffer stand-in: commands seen mid-cycle are applied at the following edge.
    always @(negedge clk) begin
        pf  = o_flag;
        ph  = o_hit;
        pkx = o_key_x;
        pky = o_key_y;
        if (o_hit) hit_cnt++;
    end

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            buf_q.delete();
        end else begin
            if (ph && buf_q.size() > 0) buf_q.delete(0);
            if (pf) buf_q.push_back('{x: int'(pkx), y: int'(pky)});
        end
        i_head_x = (buf_q.size() > 0) ? COOR_W'(buf_q[0].x) : '0;
        i_head_y = (buf_q.size() > 0) ? COOR_W'(buf_q[0].y) : '0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pix();
        i_pix_valid = 1'b1;
        step();
        i_pix_valid = 1'b0;
        if (bx == W - 1) begin
            bx = 0;
            by = (by == H - 1) ? 0 : by + 1;
        end else begin
            bx = bx + 1;
        end
    endtask

    task automatic set_key(input int x, input int y);
        i_key_valid = 1'b1;
        i_key_x     = COOR_W'(x);
        i_key_y     = COOR_W'(y);
        i_key_sin   = TRIG_W'(x * 3);
        i_key_cos   = TRIG_W'(y * 5);
        i_key_score = SCORE_W'(x + y);
        i_key_depth = DEPTH_W'(x ^ y);
    endtask

    task automatic start_frame();
        bx = 0;
        by = 0;
        i_frame_start = 1'b1;
        pix();
        i_frame_start = 1'b0;
    endtask

    task automatic finish_frame();
        while (!(bx == 0 && by == 0)) pix();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int exp_hit[6] = '{1, 0, 1, 0, 1, 0};
        int exp_occ[6] = '{2, 2, 1, 1, 0, 0};

        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Reset and idle
        check("rst_empty", o_empty, 1);
        check("rst_flag", o_flag, 0);
        check("rst_hit", o_hit, 0);
        check("rst_occ", o_occupancy, 0);
        check("rst_ready", o_ready, 0);
        check("rst_full", o_full, 0);
        set_key(7, 7);
        step();
        i_key_valid = 1'b0;
        check("idle_drop", o_drop_cnt, 1);
        check("idle_noflag", o_flag, 0);

        // Single key, continuous pixels
        start_frame();
        check("t2_ready", o_ready, 1);
        check("t2_drop_clr", o_drop_cnt, 0);
        while (!(bx == 5 && by == 0)) pix();
        set_key(20, 10);
        pix();
        i_key_valid = 1'b0;
        check("t2_flag", o_flag, 1);
        check("t2_key_x", o_key_x, 20);
        check("t2_key_y", o_key_y, 10);
        check("t2_key_sin", o_key_sin, 60);
        check("t2_occ1", o_occupancy, 1);
        h0 = hit_cnt;
        while (!(bx == 35 && by == 25)) pix();
        check("t2_no_early_hit", hit_cnt - h0, 0);
        pix();
        check("t2_hit", o_hit, 1);
        check("t2_occ0", o_occupancy, 0);
        check("t2_empty", o_empty, 1);
        pix();
        check("t2_hit_once", o_hit, 0);

        // Stall at the head target
        while (!(bx == 40 && by == 25)) pix();
        set_key(30, 20);
        pix();
        i_key_valid = 1'b0;
        check("t4_occ1", o_occupancy, 1);
        while (!(bx == 45 && by == 35)) pix();
        h0 = hit_cnt;
        i_pix_valid = 1'b0;
        repeat (5) step();
        check("t4_stall_hits", hit_cnt - h0, 1);
        check("t4_occ0", o_occupancy, 0);
        finish_frame();
        check("t4_end_hits", hit_cnt - h0, 1);
        check("t4_end_ready", o_ready, 0);

        // Fill to SIZE with far targets, then drop and flag+hit while full
        bx = 0;
        by = 0;
        i_frame_start = 1'b1;
        step();
        i_frame_start = 1'b0;
        set_key(10, 5);
        step();
        for (int i = 0; i < SIZE - 1; i++) begin
            set_key(0, 30);
            step();
        end
        i_key_valid = 1'b0;
        check("t3_occ60", o_occupancy, 60);
        check("t3_full", o_full, 1);
        set_key(1, 30);
        step();
        i_key_valid = 1'b0;
        check("t3_drop", o_drop_cnt, 1);
        check("t3_drop_noflag", o_flag, 0);
        check("t3_drop_occ", o_occupancy, 60);
        while (!(bx == 25 && by == 20)) pix();
        set_key(2, 31);
        pix();
        i_key_valid = 1'b0;
        check("t3_fh_flag", o_flag, 1);
        check("t3_fh_hit", o_hit, 1);
        check("t3_fh_occ", o_occupancy, 60);
        check("t3_fh_drop", o_drop_cnt, 1);
        finish_frame();
        check("t3_flush_ready", o_ready, 0);
        check("t3_flush_occ", o_occupancy, 60);
        n = 0;
        while (o_occupancy != 0 && n < 300) begin
            step();
            n++;
        end
        check("t3_drain_cycles", n, 119);
        check("t3_drain_empty", o_empty, 1);

        // End of frame flush with three leftovers
        start_frame();
        while (!(bx == 10 && by == 2)) pix();
        set_key(2, 30);
        pix();
        set_key(3, 31);
        pix();
        set_key(4, 35);
        pix();
        i_key_valid = 1'b0;
        check("t5_occ3", o_occupancy, 3);
        while (!(bx == W - 1 && by == H - 1)) pix();
        pix();
        check("t5_flush_ready", o_ready, 0);
        check("t5_flush_occ", o_occupancy, 3);
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("t5_hit_%0d", i), o_hit, exp_hit[i]);
            check($sformatf("t5_occ_%0d", i), o_occupancy, exp_occ[i]);
        end
        check("t5_idle_empty", o_empty, 1);
        check("t5_idle_ready", o_ready, 0);

        // Async reset during FLUSH, then a clean restart
        start_frame();
        while (!(bx == 10 && by == 3)) pix();
        set_key(5, 32);
        pix();
        set_key(6, 33);
        pix();
        set_key(7, 34);
        pix();
        i_key_valid = 1'b0;
        while (!(bx == W - 1 && by == H - 1)) pix();
        pix();
        step();
        check("t6_pre_hit", o_hit, 1);
        check("t6_pre_occ", o_occupancy, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_hit", o_hit, 0);
        check("t6_rst_occ", o_occupancy, 0);
        check("t6_rst_empty", o_empty, 1);
        check("t6_rst_ready", o_ready, 0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        start_frame();
        check("t6_restart_ready", o_ready, 1);
        check("t6_restart_occ", o_occupancy, 0);
        while (!(bx == 2 && by == 0)) pix();
        set_key(1, 0);
        pix();
        i_key_valid = 1'b0;
        check("t6_restart_flag", o_flag, 1);
        check("t6_restart_occ1", o_occupancy, 1);
        h0 = hit_cnt;
        finish_frame();
        check("t6_restart_hits", hit_cnt - h0, 1);
        check("t6_restart_end_occ", o_occupancy, 0);
        check("t6_restart_end_ready", o_ready, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
